// File: rtl/fp_addsub_mc.sv
// fp_addsub_mc: multi-cycle floating-point add/subtract, subnormals flushed to zero.
// Define FPU_RNE_EN for round-to-nearest-even; otherwise truncate and saturate on overflow.
module fp_addsub_mc #(
    parameter int N_float = 32,
    parameter int N_exp   = 8,
    parameter int N_mant  = N_float - N_exp - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_float-1:0] float_A,
    input  logic [N_float-1:0] float_B,
    input  logic               op_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_float-1:0] float_R,
    output logic [3:0]         flags
);
    // W: hidden bit + stored mantissa + guard/round/sticky
    localparam int W   = N_mant + 4;
    localparam int XW  = N_exp + 2;
    localparam int LZW = $clog2(W + 1);
    localparam logic [N_exp-1:0]     SH_MAX_C   = N_exp'(N_mant + 3);
    localparam logic [N_exp-1:0]     EXP_ONES_C = {N_exp{1'b1}};
    localparam logic signed [XW-1:0] EXP_MAX_C  = XW'((1 << N_exp) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO_C = {XW{1'b0}};
    localparam logic signed [XW-1:0] EXP_ONE_C  = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [N_float-1:0]   QNAN_C     = {1'b0, {N_exp{1'b1}}, 1'b1, {(N_mant-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t                 state_r;
    logic [N_float-1:0]     a_r, b_r, res_r, spec_val_r;
    logic                   op_sub_r, in_ready_r, out_valid_r;
    logic [3:0]             flags_r, spec_flags_r;
    logic                   special_r, sign_a_r, sign_b_r, eff_sub_r, sign_r, zero_r;
    logic [W-1:0]           ma_r, mb_r, norm_r;
    logic [W:0]             sum_r;
    logic signed [XW-1:0]   exp_r;

    logic [N_exp-1:0]       exp_a_s, exp_b_s, exp_big_s;
    logic [W-1:0]           m_a_s, m_b_s, ma_nx_s, mb_nx_s, norm_nx_s;
    logic                   nan_a_s, nan_b_s, inf_a_s, inf_b_s, sign_a_s, sign_b_s, eff_sub_s;
    logic                   special_nx_s, sign_nx_s, up_s, inexact_s;
    logic [N_float-1:0]     spec_val_nx_s, res_nx_s;
    logic [3:0]             spec_flags_nx_s, flags_nx_s;
    logic [W:0]             sum_nx_s;
    logic [LZW-1:0]         lz_s;
    logic signed [XW-1:0]   exp_norm_s, exp_fin_s;
    logic [N_mant+1:0]      rnd_s;
    logic [N_mant-1:0]      frac_s;

    // Right shift that folds every shifted-out bit into the sticky position
    function automatic logic [W-1:0] align_shift(input logic [W-1:0] m, input logic [N_exp-1:0] sh);
        logic [W-1:0] res;
        if (sh >= SH_MAX_C) begin
            res = {{(W-1){1'b0}}, |m};
        end else begin
            res = (m >> sh) | {{(W-1){1'b0}}, |(m & ~({W{1'b1}} << sh))};
        end
        return res;
    endfunction

    function automatic logic [LZW-1:0] lzc(input logic [W-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = {LZW{1'b0}};
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (found || v[i]) begin
                found = 1'b1;
            end else begin
                n = n + {{(LZW-1){1'b0}}, 1'b1};
            end
        end
        return n;
    endfunction

    // ALIGN: unpack, detect specials, shift the smaller-exponent operand
    always_comb begin
        exp_a_s  = a_r[N_float-2:N_mant];
        exp_b_s  = b_r[N_float-2:N_mant];
        m_a_s    = (exp_a_s == {N_exp{1'b0}}) ? {W{1'b0}} : {1'b1, a_r[N_mant-1:0], 3'b000};
        m_b_s    = (exp_b_s == {N_exp{1'b0}}) ? {W{1'b0}} : {1'b1, b_r[N_mant-1:0], 3'b000};
        nan_a_s  = (exp_a_s == EXP_ONES_C) && (a_r[N_mant-1:0] != {N_mant{1'b0}});
        nan_b_s  = (exp_b_s == EXP_ONES_C) && (b_r[N_mant-1:0] != {N_mant{1'b0}});
        inf_a_s  = (exp_a_s == EXP_ONES_C) && (a_r[N_mant-1:0] == {N_mant{1'b0}});
        inf_b_s  = (exp_b_s == EXP_ONES_C) && (b_r[N_mant-1:0] == {N_mant{1'b0}});
        sign_a_s = a_r[N_float-1];
        sign_b_s = b_r[N_float-1] ^ op_sub_r;
        eff_sub_s = sign_a_s ^ sign_b_s;
        if (exp_a_s >= exp_b_s) begin
            ma_nx_s   = m_a_s;
            mb_nx_s   = align_shift(m_b_s, exp_a_s - exp_b_s);
            exp_big_s = exp_a_s;
        end else begin
            ma_nx_s   = align_shift(m_a_s, exp_b_s - exp_a_s);
            mb_nx_s   = m_b_s;
            exp_big_s = exp_b_s;
        end
        special_nx_s    = 1'b1;
        spec_val_nx_s   = QNAN_C;
        spec_flags_nx_s = 4'b1000;
        if (nan_a_s || nan_b_s || (inf_a_s && inf_b_s && eff_sub_s)) begin
            spec_val_nx_s   = QNAN_C;
            spec_flags_nx_s = 4'b1000;
        end else if (inf_a_s) begin
            spec_val_nx_s   = {sign_a_s, EXP_ONES_C, {N_mant{1'b0}}};
            spec_flags_nx_s = 4'b0000;
        end else if (inf_b_s) begin
            spec_val_nx_s   = {sign_b_s, EXP_ONES_C, {N_mant{1'b0}}};
            spec_flags_nx_s = 4'b0000;
        end else begin
            special_nx_s = 1'b0;
        end
    end

    // ADD: magnitude add/subtract; exact cancellation yields +0
    always_comb begin
        sum_nx_s  = {(W+1){1'b0}};
        sign_nx_s = sign_a_r;
        if (!eff_sub_r) begin
            sum_nx_s  = {1'b0, ma_r} + {1'b0, mb_r};
            sign_nx_s = sign_a_r;
        end else if (ma_r > mb_r) begin
            sum_nx_s  = {1'b0, ma_r - mb_r};
            sign_nx_s = sign_a_r;
        end else if (mb_r > ma_r) begin
            sum_nx_s  = {1'b0, mb_r - ma_r};
            sign_nx_s = sign_b_r;
        end else begin
            sum_nx_s  = {(W+1){1'b0}};
            sign_nx_s = 1'b0;
        end
    end

    // NORM: carry-out right shift or leading-zero left shift
    always_comb begin
        lz_s = lzc(sum_r[W-1:0]);
        if (sum_r[W]) begin
            norm_nx_s  = {sum_r[W:2], sum_r[1] | sum_r[0]};
            exp_norm_s = exp_r + EXP_ONE_C;
        end else begin
            norm_nx_s  = sum_r[W-1:0] << lz_s;
            exp_norm_s = exp_r - $signed({{(XW-LZW){1'b0}}, lz_s});
        end
    end

    // ROUND: round, renormalise on mantissa carry, classify the exponent
    always_comb begin
        inexact_s = |norm_r[2:0];
`ifdef FPU_RNE_EN
        up_s = norm_r[2] & (norm_r[1] | norm_r[0] | norm_r[3]);
`else
        up_s = 1'b0;
`endif
        rnd_s = {1'b0, norm_r[W-1:3]} + {{(N_mant+1){1'b0}}, up_s};
        if (rnd_s[N_mant+1]) begin
            frac_s    = rnd_s[N_mant:1];
            exp_fin_s = exp_r + EXP_ONE_C;
        end else begin
            frac_s    = rnd_s[N_mant-1:0];
            exp_fin_s = exp_r;
        end
        res_nx_s   = {sign_r, exp_fin_s[N_exp-1:0], frac_s};
        flags_nx_s = {3'b000, inexact_s};
        if (special_r) begin
            res_nx_s   = spec_val_r;
            flags_nx_s = spec_flags_r;
        end else if (zero_r) begin
            res_nx_s   = {sign_r, {(N_float-1){1'b0}}};
            flags_nx_s = 4'b0000;
        end else if (exp_fin_s >= EXP_MAX_C) begin
`ifdef FPU_RNE_EN
            res_nx_s = {sign_r, EXP_ONES_C, {N_mant{1'b0}}};
`else
            res_nx_s = {sign_r, {(N_exp-1){1'b1}}, 1'b0, {N_mant{1'b1}}};
`endif
            flags_nx_s = 4'b0101;
        end else if (exp_fin_s <= EXP_ZERO_C) begin
            res_nx_s   = {sign_r, {(N_float-1){1'b0}}};
            flags_nx_s = 4'b0011;
        end else begin
            res_nx_s   = {sign_r, exp_fin_s[N_exp-1:0], frac_s};
            flags_nx_s = {3'b000, inexact_s};
        end
    end

    // FSM with pipeline registers and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            res_r        <= {N_float{1'b0}};
            flags_r      <= 4'b0000;
            a_r          <= {N_float{1'b0}};
            b_r          <= {N_float{1'b0}};
            op_sub_r     <= 1'b0;
            ma_r         <= {W{1'b0}};
            mb_r         <= {W{1'b0}};
            exp_r        <= EXP_ZERO_C;
            sign_a_r     <= 1'b0;
            sign_b_r     <= 1'b0;
            eff_sub_r    <= 1'b0;
            special_r    <= 1'b0;
            spec_val_r   <= {N_float{1'b0}};
            spec_flags_r <= 4'b0000;
            sum_r        <= {(W+1){1'b0}};
            sign_r       <= 1'b0;
            zero_r       <= 1'b0;
            norm_r       <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= float_A;
                        b_r        <= float_B;
                        op_sub_r   <= op_sub;
                        in_ready_r <= 1'b0;
                        state_r    <= ALIGN;
                    end
                end
                ALIGN: begin
                    ma_r         <= ma_nx_s;
                    mb_r         <= mb_nx_s;
                    exp_r        <= $signed({2'b00, exp_big_s});
                    sign_a_r     <= sign_a_s;
                    sign_b_r     <= sign_b_s;
                    eff_sub_r    <= eff_sub_s;
                    special_r    <= special_nx_s;
                    spec_val_r   <= spec_val_nx_s;
                    spec_flags_r <= spec_flags_nx_s;
                    state_r      <= ADD;
                end
                ADD: begin
                    sum_r   <= sum_nx_s;
                    sign_r  <= sign_nx_s;
                    state_r <= NORM;
                end
                NORM: begin
                    norm_r  <= norm_nx_s;
                    exp_r   <= exp_norm_s;
                    zero_r  <= (sum_r == {(W+1){1'b0}});
                    state_r <= ROUND;
                end
                ROUND: begin
                    res_r       <= res_nx_s;
                    flags_r     <= flags_nx_s;
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign float_R   = res_r;
    assign flags     = flags_r;
endmodule

// File: tb/tb_fp_addsub_mc.sv
// Directed self-checking bench for fp_addsub_mc (default 32-bit build, either rounding mode).
module tb_fp_addsub_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, op_sub, out_valid, out_ready;
    logic [31:0] float_A, float_B, float_R;
    logic [3:0]  flags;
    int          n_cmp = 0;
    int          n_bad = 0;

    fp_addsub_mc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .float_A(float_A), .float_B(float_B), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .float_R(float_R), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, want);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] want_r, input logic [3:0] want_f,
                          input int hold);
        int tmo;
        int cyc;
        @(negedge clk);
        tmo = 0;
        while (!in_ready && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        check_val({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        float_A  = a;
        float_B  = b;
        op_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val({tag, "_lat"}, cyc, 32'd4);
        check_val({tag, "_R"}, float_R, want_r);
        check_val({tag, "_flags"}, {28'd0, flags}, {28'd0, want_f});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_val({tag, "_holdR"}, float_R, want_r);
            check_val({tag, "_holdV"}, {31'd0, out_valid}, 32'd1);
            check_val({tag, "_holdRdy"}, {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, "_vdrop"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_sub    = 1'b0;
        float_A   = 32'd0;
        float_B   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_R", float_R, 32'd0);
        check_val("rst_flags", {28'd0, flags}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 0);
        run_op("three_minus_five", 32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000, 4'b0000, 0);
        run_op("cancel", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 0);
        run_op("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 0);
        run_op("negzero_sum", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 0);
        run_op("inf_plus_one", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 0);
        run_op("one_minus_inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, 0);
        run_op("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 0);
        run_op("nan_in", 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 0);
        run_op("underflow", 32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011, 0);
        run_op("subnorm_flush", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 0);
        run_op("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 0);
        run_op("sticky_only", 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 4'b0001, 0);
`ifdef FPU_RNE_EN
        run_op("round_up", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 0);
        run_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 0);
`else
        run_op("round_trunc", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800001, 4'b0001, 0);
        run_op("overflow_sat", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 4'b0101, 0);
`endif
        run_op("hold_done", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 10);

        // Abort an operation while it sits in NORM
        @(negedge clk);
        float_A  = 32'h3F800000;
        float_B  = 32'h3F800000;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("midrst_ready", {31'd0, in_ready}, 32'd1);
        check_val("midrst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_val("midrst_novalid", {31'd0, out_valid}, 32'd0);
        end
        run_op("after_rst", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fp_addsub_mc.md
FP_ADDSUB_MC -- requirements
Module: fp_addsub_mc

Interface
REQ-001 Parameter N_float, default 32: total float width.
REQ-002 Parameter N_exp, default 8: exponent field width; N_mant SHALL equal N_float-N_exp-1.
REQ-003 Parameter N_mant, default 23: stored mantissa width, with the hidden 1 implicit.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1: operands present.
REQ-007 Port in_ready, output, 1: block accepts operands.
REQ-008 Port float_A, input, N_float: first operand, IEEE-754 layout {sign, exp, mant}.
REQ-009 Port float_B, input, N_float: second operand.
REQ-010 Port op_sub, input, 1: 0 computes A+B, 1 computes A-B.
REQ-011 Port out_valid, output, 1: float_R and flags are valid.
REQ-012 Port out_ready, input, 1: consumer takes the result.
REQ-013 Port float_R, output, N_float: the result.
REQ-014 Port flags, output, 4: {invalid, overflow, underflow, inexact}.

Function
REQ-015 FSM states SHALL be IDLE, ALIGN, ADD, NORM, ROUND and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept SHALL occur when in_valid&&in_ready; A, B and op_sub are registered and the state moves to ALIGN.
REQ-017 Each of ALIGN, ADD, NORM and ROUND SHALL take exactly one cycle, so out_valid rises at the 4th rising edge after the accepting edge.
REQ-018 ALIGN: the operand with the smaller exponent SHALL be right-shifted by |expA-expB| in one cycle, keeping guard and round bits plus an OR-reduced sticky bit; shifts >= N_mant+3 leave only sticky.
REQ-019 ADD: effective subtract = signA ^ signB ^ op_sub; magnitudes are compared and the result sign is the sign of the larger magnitude (with op_sub applied to B).
REQ-020 NORM: on carry-out, shift right 1 and increment the exponent; otherwise a leading-zero count drives a single-cycle left shift and the exponent is decremented by that count.
REQ-021 ROUND: behaviour is set by REQ-033/034; a mantissa carry from rounding SHALL renormalise and increment the exponent.
REQ-022 DONE: float_R, flags and out_valid SHALL hold stable until out_ready=1; on that edge the FSM goes to IDLE. No new operand is accepted in the same cycle.
REQ-023 An input with exp==0 SHALL be treated as signed zero (subnormals flushed).
REQ-024 NaN input, or inf-inf under the effective operation, SHALL give the canonical qNaN {0, all-ones exp, 1 then zeros} with invalid=1.
REQ-025 An infinite operand with otherwise valid operands SHALL give that infinity with the correct sign and no flags.
REQ-026 Exponent overflow SHALL give a signed infinity with overflow=1 and inexact=1.
REQ-027 A normalised exponent <= 0 SHALL give signed zero with underflow=1 and inexact=1.
REQ-028 Exact cancellation SHALL give +0; (-0)+(-0) SHALL give -0.
REQ-029 inexact SHALL equal the OR of the guard, round and sticky bits lost in rounding.

Reset
REQ-030 rst SHALL force state=IDLE, out_valid=0, float_R=0 and flags=0 at any time, including mid-operation; in_ready=1 while in reset.
REQ-031 An operation in flight at reset SHALL be discarded and produce no result.
REQ-032 After rst deasserts, the first accept is allowed on the first rising edge.

Configuration
REQ-033 With macro FPU_RNE_EN defined, ROUND SHALL apply round-to-nearest, ties-to-even.
REQ-034 Without FPU_RNE_EN, ROUND SHALL truncate (round toward zero); inexact is still reported and overflow saturates to the largest finite value instead of infinity.

Verification
REQ-035 0x3F800000+0x3F800000, op_sub=0 -> float_R=0x40000000, flags=0, out_valid at the 4th edge after accept.
REQ-036 0x40400000-0x40A00000 (3-5) -> 0xC0000000; 0x3F800000-0x3F800000 -> 0x00000000, flags=0.
REQ-037 0x3F800001+0x33800000 -> 0x3F800002 with inexact=1 (FPU_RNE_EN defined); 0x3F800001 with inexact=1 (not defined).
REQ-038 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, flags=0b0101 (FPU_RNE_EN); 0x7F7FFFFF (not defined). 0x7F800000-0x7F800000 -> 0x7FC00000, flags=0b1000.
REQ-039 out_ready held low 10 cycles in DONE -> float_R and out_valid stable, in_ready=0; rst asserted in NORM -> out_valid stays 0 and in_ready=1 immediately.
